// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and bit-timing helper for the UART stream FIFO
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with extra-MSB pointers and a registered head
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd, w_rd_n;
  logic w_pop, w_push;
  assign o_level = r_wr - r_rd;
  assign o_empty = o_level == '0;
  assign o_full = o_level[AW];
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  assign w_rd_n = r_rd + {{AW{1'b0}}, w_pop};
  // storage array; a pop in the same cycle frees the slot a full-FIFO push reuses
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  // pointers and registered head; a push into the slot that becomes head bypasses the array
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      o_data <= '0;
    end else begin
      r_wr <= r_wr + {{AW{1'b0}}, w_push};
      r_rd <= w_rd_n;
      o_data <= (w_push && r_wr[AW-1:0] == w_rd_n[AW-1:0]) ? i_data : r_mem[w_rd_n[AW-1:0]];
    end
  end
endmodule

// File: rtl/uart_stream_fifo.sv
// uart_stream_fifo: buffered full-duplex UART with valid/ready streams and error reporting
module uart_stream_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BIT_RATE = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            uart_rxd,
  output logic                            uart_txd,
  input  logic [PAYLOAD_BITS-1:0]         s_tdata,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  output logic [PAYLOAD_BITS-1:0]         m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  input  logic                            clear_err,
  output logic                            rx_overflow,
  output logic                            rx_frame_err,
  output logic                            rx_break,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]     rx_level,
  output logic [$clog2(FIFO_DEPTH):0]     tx_level
);
  localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  logic r_rxd_s1, r_rxd_s2, r_rxd_prev;
  state_t r_rx_state, w_rx_state_n, r_tx_state, w_tx_state_n;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_n, r_tx_cnt, w_tx_cnt_n;
  logic [3:0] r_rx_bit, w_rx_bit_n, r_tx_bit, w_tx_bit_n;
  logic [PAYLOAD_BITS-1:0] r_rx_shift, w_rx_shift_n, r_tx_shift, w_tx_shift_n, w_tx_head;
  logic r_rx_hold, w_rx_hold_n, r_rx_push, w_rx_push_n, r_rx_brk, w_rx_brk_n, w_rx_ferr;
  logic r_txd, w_txd_n, w_tx_pop, w_tx_end;
  logic r_ovf, r_ferr, w_rx_full, w_rx_empty, w_rx_pop, w_rx_drop, w_tx_full, w_tx_empty;
  uart_sync_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .i_push(r_rx_push), .i_data(r_rx_shift), .i_pop(w_rx_pop),
    .o_data(m_tdata), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_level(rx_level)
  );
  uart_sync_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .i_push(s_tvalid && s_tready), .i_data(s_tdata), .i_pop(w_tx_pop),
    .o_data(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_level(tx_level)
  );
  assign m_tvalid = !w_rx_empty;
  assign w_rx_pop = m_tready && !w_rx_empty;
  assign w_rx_drop = r_rx_push && w_rx_full && !w_rx_pop;
  assign s_tready = !w_tx_full;
  assign uart_txd = r_txd;
  assign tx_busy = (r_tx_state != IDLE) || !w_tx_empty;
  assign rx_overflow = r_ovf;
  assign rx_frame_err = r_ferr;
  assign rx_break = r_rx_brk;
  // two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk)
    if (reset) {r_rxd_s1, r_rxd_s2, r_rxd_prev} <= '1;
    else {r_rxd_s1, r_rxd_s2, r_rxd_prev} <= {uart_rxd, r_rxd_s1, r_rxd_s2};
  // RX next state: mid-bit sampling; a break holds in STOP until the line recovers
  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n = r_rx_cnt + 1'b1;
    w_rx_bit_n = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_hold_n = r_rx_hold;
    w_rx_push_n = 1'b0;
    w_rx_brk_n = 1'b0;
    w_rx_ferr = 1'b0;
    case (r_rx_state)
      IDLE: begin
        w_rx_cnt_n = '0;
        if (r_rxd_prev && !r_rxd_s2) w_rx_state_n = START;
      end
      START: if (r_rx_cnt == HALF_END) begin
        w_rx_cnt_n = '0;
        w_rx_bit_n = '0;
        w_rx_state_n = r_rxd_s2 ? IDLE : DATA;
      end
      DATA: if (r_rx_cnt == BIT_END) begin
        w_rx_cnt_n = '0;
        w_rx_shift_n = {r_rxd_s2, r_rx_shift[PAYLOAD_BITS-1:1]};
        w_rx_bit_n = r_rx_bit + 1'b1;
        if (r_rx_bit == 4'(PAYLOAD_BITS - 1)) w_rx_state_n = STOP;
      end
      STOP: if (r_rx_hold) begin
        w_rx_cnt_n = '0;
        if (r_rxd_s2) begin
          w_rx_hold_n = 1'b0;
          w_rx_state_n = IDLE;
        end
      end else if (r_rx_cnt == BIT_END) begin
        w_rx_cnt_n = '0;
        if (r_rxd_s2) begin
          w_rx_push_n = 1'b1;
          w_rx_state_n = IDLE;
        end else if (r_rx_shift == '0) begin
          w_rx_brk_n = 1'b1;
          w_rx_hold_n = 1'b1;
        end else begin
          w_rx_ferr = 1'b1;
          w_rx_state_n = IDLE;
        end
      end
      default: w_rx_state_n = IDLE;
    endcase
  end
  // TX next state: pop on start, LSB first, chain straight into the next frame
  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n = r_tx_cnt + 1'b1;
    w_tx_bit_n = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    w_txd_n = r_txd;
    w_tx_pop = 1'b0;
    w_tx_end = r_tx_cnt == BIT_END;
    case (r_tx_state)
      IDLE: begin
        w_tx_cnt_n = '0;
        if (!w_tx_empty) begin
          w_tx_pop = 1'b1;
          w_tx_state_n = START;
          w_tx_shift_n = w_tx_head;
          w_txd_n = 1'b0;
        end
      end
      START: if (w_tx_end) begin
        w_tx_cnt_n = '0;
        w_tx_bit_n = '0;
        w_tx_state_n = DATA;
        w_txd_n = r_tx_shift[0];
      end
      DATA: if (w_tx_end) begin
        w_tx_cnt_n = '0;
        if (r_tx_bit == 4'(PAYLOAD_BITS - 1)) begin
          w_tx_bit_n = '0;
          w_tx_state_n = STOP;
          w_txd_n = 1'b1;
        end else begin
          w_tx_bit_n = r_tx_bit + 1'b1;
          w_tx_shift_n = r_tx_shift >> 1;
          w_txd_n = r_tx_shift[1];
        end
      end
      STOP: if (w_tx_end) begin
        w_tx_cnt_n = '0;
        if (r_tx_bit == 4'(STOP_BITS - 1)) begin
          w_tx_bit_n = '0;
          if (!w_tx_empty) begin
            w_tx_pop = 1'b1;
            w_tx_state_n = START;
            w_tx_shift_n = w_tx_head;
            w_txd_n = 1'b0;
          end else w_tx_state_n = IDLE;
        end else w_tx_bit_n = r_tx_bit + 1'b1;
      end
      default: w_tx_state_n = IDLE;
    endcase
  end
  // state and datapath registers; error events beat a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_shift <= '0;
      r_rx_hold <= 1'b0;
      r_rx_push <= 1'b0;
      r_rx_brk <= 1'b0;
      r_tx_state <= IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_shift <= '0;
      r_txd <= 1'b1;
      r_ovf <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_n;
      r_rx_cnt <= w_rx_cnt_n;
      r_rx_bit <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n;
      r_rx_hold <= w_rx_hold_n;
      r_rx_push <= w_rx_push_n;
      r_rx_brk <= w_rx_brk_n;
      r_tx_state <= w_tx_state_n;
      r_tx_cnt <= w_tx_cnt_n;
      r_tx_bit <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
      r_txd <= w_txd_n;
      r_ovf <= w_rx_drop || (r_ovf && !clear_err);
      r_ferr <= w_rx_ferr || (r_ferr && !clear_err);
    end
  end
endmodule

// File: tb/tb_uart_stream_fifo.sv
// tb_uart_stream_fifo: directed UART frames checked against a queue model and per-cycle line model
module tb_uart_stream_fifo;
  localparam int CPB = 32;
  localparam int DEPTH = 16;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic line = 1'b1, loop = 1'b0, mon_sel = 1'b0;
  logic uart_rxd, uart_txd, s_tvalid = 1'b0, s_tready, m_tvalid, m_tready = 1'b0, clear_err = 1'b0;
  logic [7:0] s_tdata = '0, m_tdata;
  logic rx_overflow, rx_frame_err, rx_break, tx_busy;
  logic [4:0] rx_level, tx_level;
  logic uart_txd2, s_tvalid2 = 1'b0, s_tready2, m_tvalid2, tx_busy2;
  logic [7:0] s_tdata2 = '0, m_tdata2;
  logic rx_overflow2, rx_frame_err2, rx_break2;
  logic [4:0] rx_level2, tx_level2;
  logic tx_mon, busy_mon;
  assign uart_rxd = loop ? uart_txd : line;
  assign tx_mon = mon_sel ? uart_txd2 : uart_txd;
  assign busy_mon = mon_sel ? tx_busy2 : tx_busy;
  uart_stream_fifo #(.CLK_HZ(3200), .BIT_RATE(100), .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .clear_err(clear_err),
    .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err), .rx_break(rx_break),
    .tx_busy(tx_busy), .rx_level(rx_level), .tx_level(tx_level)
  );
  uart_stream_fifo #(.CLK_HZ(3200), .BIT_RATE(100), .PAYLOAD_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(reset), .uart_rxd(uart_txd2), .uart_txd(uart_txd2),
    .s_tdata(s_tdata2), .s_tvalid(s_tvalid2), .s_tready(s_tready2),
    .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tready(1'b1), .clear_err(1'b0),
    .rx_overflow(rx_overflow2), .rx_frame_err(rx_frame_err2), .rx_break(rx_break2),
    .tx_busy(tx_busy2), .rx_level(rx_level2), .tx_level(tx_level2)
  );
  int checks = 0, failures = 0, rx_got = 0, rx2_got = 0, brk_cnt = 0;
  logic [7:0] exp_q[$], exp2_q[$];
  logic exp_ovf = 1'b0;
  logic [7:0] tx_bytes [4];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Model of what the RX FIFO must hold: a full FIFO with no consumer drops the byte
  task automatic model_rx(input logic [7:0] b);
    if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(b);
  endtask
  task automatic drive_frame(input logic [7:0] d, input logic stop);
    line = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      tick(CPB);
    end
    if (stop) model_rx(d);
    line = stop;
    tick(CPB);
    line = 1'b1;
    tick(2 * CPB);
  endtask
  task automatic send_bytes(input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      if (sel) begin
        s_tdata2 = tx_bytes[i];
        s_tvalid2 = 1'b1;
        check("s_tready2", 32'(s_tready2), 1);
        exp2_q.push_back(tx_bytes[i]);
      end else begin
        s_tdata = tx_bytes[i];
        s_tvalid = 1'b1;
        check("s_tready", 32'(s_tready), 1);
        if (loop) model_rx(tx_bytes[i]);
      end
      tick();
    end
    s_tvalid = 1'b0;
    s_tvalid2 = 1'b0;
  endtask
  // Expected serial line, cycle by cycle: start 0, 8 data LSB first, stops high, frames back to back
  task automatic tx_check(input int n, input int stops);
    int nb, k, f, b;
    logic e;
    nb = 9 + stops;
    k = 0;
    @(negedge clk);
    while (tx_mon !== 1'b0 && k < 4 * CPB) begin
      @(negedge clk);
      k++;
    end
    check("tx_start_seen", 32'(tx_mon), 0);
    for (int i = 0; i < n * nb * CPB; i++) begin
      f = i / (nb * CPB);
      b = (i % (nb * CPB)) / CPB;
      e = (b == 0) ? 1'b0 : (b <= 8) ? tx_bytes[f][b-1] : 1'b1;
      check("tx_bit", 32'(tx_mon), 32'(e));
      @(negedge clk);
    end
    check("tx_idle_line", 32'(tx_mon), 1);
    check("tx_busy_done", 32'(busy_mon), 0);
  endtask
  // Stream compare: any valid head must be the model's oldest byte; handshakes retire it
  always @(negedge clk) begin
    if (!reset && m_tvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected got=%0h want=none t=%0t", m_tdata, $time);
      end else begin
        check("rx_data", 32'(m_tdata), 32'(exp_q[0]));
        if (m_tready) begin
          void'(exp_q.pop_front());
          rx_got++;
        end
      end
    end
    if (!reset && m_tvalid2) begin
      if (exp2_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx2_unexpected got=%0h want=none t=%0t", m_tdata2, $time);
      end else begin
        check("rx2_data", 32'(m_tdata2), 32'(exp2_q[0]));
        void'(exp2_q.pop_front());
        rx2_got++;
      end
    end
    if (rx_break === 1'b1) brk_cnt++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  initial begin
    int k, g, b0;
    tick(3);
    check("rst_txd", 32'(uart_txd), 1);
    check("rst_s_tready", 32'(s_tready), 1);
    check("rst_m_tvalid", 32'(m_tvalid), 0);
    check("rst_m_tdata", 32'(m_tdata), 0);
    check("rst_flags", 32'({rx_overflow, rx_frame_err, rx_break, tx_busy}), 0);
    check("rst_levels", 32'({rx_level, tx_level}), 0);
    reset = 1'b0;
    tick(2);
    loop = 1'b1;
    m_tready = 1'b1;
    tx_bytes = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    fork
      send_bytes(4, 1'b0);
      tx_check(4, 1);
    join
    tick(4);
    check("loop_all_rx", 32'(rx_got), 4);
    check("loop_model_empty", exp_q.size(), 0);
    check("loop_rx_level", 32'(rx_level), 0);
    loop = 1'b0;
    m_tready = 1'b0;
    for (int i = 1; i <= 17; i++) drive_frame(8'(i), 1'b1);
    check("ovf_level", 32'(rx_level), 16);
    check("ovf_level_model", 32'(rx_level), exp_q.size());
    check("ovf_flag", 32'(rx_overflow), 1);
    check("ovf_flag_model", 32'(rx_overflow), 32'(exp_ovf));
    check("ovf_head", 32'(m_tdata), 32'h01);
    check("ovf_s_tready", 32'(s_tready), 1);
    m_tready = 1'b1;
    for (k = 0; k < 4 * DEPTH && exp_q.size() != 0; k++) tick();
    tick(2);
    check("drain_model_empty", exp_q.size(), 0);
    check("drain_count", 32'(rx_got), 20);
    check("drain_level", 32'(rx_level), 0);
    check("drain_m_tvalid", 32'(m_tvalid), 0);
    check("ovf_sticky", 32'(rx_overflow), 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_cleared", 32'(rx_overflow), 0);
    drive_frame(8'h5A, 1'b0);
    check("ferr_flag", 32'(rx_frame_err), 1);
    check("ferr_nopush", 32'(rx_level), 0);
    check("ferr_no_break", 32'(brk_cnt), 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("ferr_cleared", 32'(rx_frame_err), 0);
    b0 = brk_cnt;
    line = 1'b0;
    tick(20 * CPB);
    line = 1'b1;
    tick(2 * CPB);
    check("brk_pulses", brk_cnt - b0, 1);
    check("brk_nopush", 32'(rx_level), 0);
    check("brk_no_ferr", 32'(rx_frame_err), 0);
    g = rx_got;
    drive_frame(8'h33, 1'b1);
    check("brk_next_rx", rx_got - g, 1);
    b0 = brk_cnt;
    line = 1'b0;
    tick(4);
    line = 1'b1;
    tick(2 * CPB);
    check("glitch_nopush", 32'(rx_level), 0);
    check("glitch_no_err", 32'({rx_frame_err, rx_overflow}), 0);
    check("glitch_no_break", brk_cnt - b0, 0);
    g = rx_got;
    drive_frame(8'h96, 1'b1);
    check("glitch_next_rx", rx_got - g, 1);
    tx_bytes[0] = 8'hA5;
    send_bytes(1, 1'b0);
    k = 0;
    while (uart_txd !== 1'b0 && k < 4 * CPB) begin
      tick();
      k++;
    end
    check("rst_tx_started", 32'(uart_txd), 0);
    tick(2 * CPB + 5);
    check("rst_mid_bit1", 32'(uart_txd), 0);
    check("rst_busy_before", 32'(tx_busy), 1);
    reset = 1'b1;
    tick();
    check("rst_tx_txd", 32'(uart_txd), 1);
    check("rst_tx_level", 32'(tx_level), 0);
    check("rst_tx_busy", 32'(tx_busy), 0);
    reset = 1'b0;
    tick();
    check("rst_tx_stays_idle", 32'({uart_txd, tx_busy}), 32'b10);
    tx_bytes[0] = 8'hC3;
    fork
      send_bytes(1, 1'b0);
      tx_check(1, 1);
    join
    mon_sel = 1'b1;
    tx_bytes[0] = 8'h81;
    tx_bytes[1] = 8'h7E;
    fork
      send_bytes(2, 1'b1);
      tx_check(2, 2);
    join
    tick(4);
    check("stop2_rx_count", 32'(rx2_got), 2);
    check("stop2_model_empty", exp2_q.size(), 0);
    check("stop2_quiet", 32'({rx_overflow2, rx_frame_err2, rx_break2, rx_level2, tx_level2}), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_stream_fifo.md
Name: uart_stream_fifo

Overview:
Parametrised full-duplex UART transceiver with independent receive and transmit FIFOs and valid/ready stream interfaces. It is the buffered successor to the unbuffered rx/tx pair: it adds configurable stop bits, FIFO depth, overflow and framing-error reporting, and backpressure. It sits between a board UART pin pair and fabric logic such as a command parser or echo path.

Parameters:
CLK_HZ, 100000000, clk frequency in Hz
BIT_RATE, 115200, line rate; CYCLES_PER_BIT = CLK_HZ/BIT_RATE, integer floor
PAYLOAD_BITS, 8, data bits per frame, range 5..9, LSB first
STOP_BITS, 1, stop bits transmitted, 1 or 2; receiver always checks exactly one
FIFO_DEPTH, 16, entries per FIFO, power of two, minimum 2

Ports:
clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high
uart_rxd  in  1  async serial input; idle high
uart_txd  out  1  serial output; idle high
s_tdata  in  PAYLOAD_BITS  byte to transmit
s_tvalid  in  1  s_tdata valid
s_tready  out  1  TX FIFO not full
m_tdata  out  PAYLOAD_BITS  received byte (RX FIFO head)
m_tvalid  out  1  RX FIFO not empty
m_tready  in  1  consumer accepts head
clear_err  in  1  one-cycle pulse clears sticky error flags
rx_overflow  out  1  sticky; a byte was dropped because the RX FIFO was full
rx_frame_err  out  1  sticky; stop bit sampled low on a non-break frame
rx_break  out  1  one-cycle pulse; all data bits and the stop bit were 0
tx_busy  out  1  serialiser active or TX FIFO non-empty
rx_level  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy

Behaviour:
- Reset values: uart_txd=1, s_tready=1, m_tvalid=0, m_tdata=0, all error flags 0, rx_break=0, tx_busy=0, both levels 0. Both FIFOs are emptied and both FSMs go to IDLE. Reset mid-frame aborts the frame; uart_txd returns high on the next cycle.
- uart_rxd passes through a two-flop synchroniser initialised to 1. The RX path adds 2 cycles of input latency.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE -> START on a synchronised falling edge.
  - START waits CYCLES_PER_BIT/2 cycles, then samples. If the line is high, the event is a glitch and the FSM returns to IDLE. Otherwise it goes to DATA.
  - DATA samples every CYCLES_PER_BIT cycles, PAYLOAD_BITS samples, LSB first.
  - STOP samples once.
    - High: the byte is pushed to the RX FIFO in the cycle after sampling.
    - Low with data==0: rx_break pulses, nothing is pushed, and the FSM waits for the line to go high before entering IDLE.
    - Low with data!=0: rx_frame_err is set, nothing is pushed, and the FSM enters IDLE.
- RX push while the FIFO is full: the byte is dropped, rx_overflow is set, and the FIFO contents are unchanged.
- A push and a pop in the same cycle while full are legal: the pop is honoured first, so no overflow occurs.
- clear_err clears the sticky flags. An error event in the same cycle as clear_err wins, and the flag stays 1.
- Stream handshakes: a transfer occurs on the rising clk edge where valid && ready.
  - m_tdata is the registered FIFO head and is stable while m_tvalid && !m_tready.
  - m_tvalid rises 1 cycle after the push.
  - s_tdata is captured on handshake. s_tready deasserts in the cycle after the FIFO becomes full.
- TX FSM (IDLE, START, DATA, STOP):
  - In IDLE with the TX FIFO non-empty, pop the head and drive start (0) in the next cycle.
  - Each bit lasts exactly CYCLES_PER_BIT cycles.
  - Data bits go out LSB first, followed by STOP_BITS high bits.
  - After the last stop bit, the FSM re-enters START directly if the FIFO is non-empty (back-to-back frames, no idle gap), otherwise IDLE.
- Levels: the count increments on push and decrements on pop. A simultaneous push and pop leaves it unchanged. Levels saturate at FIFO_DEPTH and 0 by construction; wrap-around of the pointers is handled with an extra MSB.
- Bit counters are $clog2(CYCLES_PER_BIT) wide. A counter compare reaching CYCLES_PER_BIT-1 ends the bit.

Decomposition:
- Package uart_pkg: localparam CYCLES_PER_BIT derivation function, and FSM state encoding IDLE/START/DATA/STOP (2 bits) shared by RX and TX.
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level; registered head output) is instantiated twice.
- RX and TX FSMs live inline in uart_stream_fifo.

Test Plan:
- Run with CLK_HZ=100e6, BIT_RATE=115200 (868 cycles/bit), PAYLOAD_BITS=8, STOP_BITS=1, FIFO_DEPTH=16.
- Loopback (uart_txd->uart_rxd), send 0x55, 0xA3, 0x00, 0xFF with m_tready=1 -> the same four bytes appear in order on m_tdata. Each frame spans 10*868 cycles and there are no idle gaps between frames.
- Hold m_tready=0 and receive 17 bytes 0x01..0x11 -> rx_level=16, rx_overflow=1, and draining yields 0x01..0x10. A clear_err pulse then sets rx_overflow=0.
- Drive a frame with data 0x5A and the stop bit low -> rx_frame_err=1 and no push. Drive all-zero data with the stop bit low and the line held low for 2 frames -> one rx_break pulse, no push, and the next valid 0x33 is received.
- Drive a 100-cycle low glitch on uart_rxd -> no push, no error, and the FSM is back in IDLE.
- Assert reset during a TX data bit -> uart_txd=1 next cycle, tx_level=0, tx_busy=0. The next queued 0xC3 is transmitted correctly.
- Set STOP_BITS=2, send 0x81 -> the stop phase is high for 1736 cycles before the next start bit.
